// File: rtl/frame_scan_reader_if.sv
// Bus bundle between the frame scan reader, its frame buffer read port and
// the downstream video encoder.
interface frame_scan_reader_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              en;
    logic [ADDR_W-1:0] ReadAdd;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] Pixel;
    logic              HSync;
    logic              VSync;
    logic              DE;
    logic              FrameStart;

    // Reader side: drives the read address and the video stream.
    modport master (
        input  en,
        input  ReadData,
        output ReadAdd,
        output Pixel,
        output HSync,
        output VSync,
        output DE,
        output FrameStart
    );

    // Environment side: frame buffer read port plus encoder/controller.
    modport slave (
        output en,
        output ReadData,
        input  ReadAdd,
        input  Pixel,
        input  HSync,
        input  VSync,
        input  DE,
        input  FrameStart
    );
endinterface

// File: rtl/frame_scan_reader.sv
// Read side of a line-doubled frame buffer: generates raster timing, drives
// the buffer read address and emits an aligned pixel/HS/VS/DE/FrameStart
// stream three clocks after each raster position.
module frame_scan_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LINE_REP = 2,
    parameter int SYNC_POL = 0,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12
) (
    input logic               clk,
    input logic               rstn,
    frame_scan_reader_if.master bus
);

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(H_TOT);
    localparam int VW     = $clog2(V_TOT);
    localparam int RW     = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;
    // Control stages ahead of the output register; the buffer read adds the
    // third cycle of latency in the data path.
    localparam int STAGES = 2;
    localparam logic SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

    // Bit positions inside the control word carried down the pipeline.
    localparam int C_HS = 0;
    localparam int C_VS = 1;
    localparam int C_DE = 2;
    localparam int C_FS = 3;

    typedef enum logic {IDLE, SCAN} scanState_t;

    scanState_t        state;
    scanState_t        stateNext;
    logic [HW-1:0]     hCnt;
    logic [VW-1:0]     vCnt;
    logic [RW-1:0]     repCnt;
    logic [ADDR_W-1:0] lineBase;
    logic              hEnd;
    logic              vEnd;
    logic              frameEnd;
    logic              pixActive;
    logic [3:0]        ctrlNow;

    assign hEnd      = (hCnt == HW'(H_TOT - 1));
    assign vEnd      = (vCnt == VW'(V_TOT - 1));
    assign frameEnd  = hEnd && vEnd;
    assign pixActive = (state == SCAN) && (hCnt < HW'(H_ACTIVE)) && (vCnt < VW'(V_ACTIVE));

    // Scan state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= stateNext;
    end

    // Enable is sampled only at a frame boundary so frames are never cut short.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (bus.en) stateNext = SCAN;
            SCAN: if (frameEnd && !bus.en) stateNext = IDLE;
        endcase
    end

    // Raster counters; they sit at 0 while idle and wrap to 0 on the last position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (state == SCAN) begin
            if (hEnd) begin
                hCnt <= '0;
                vCnt <= vEnd ? '0 : vCnt + 1'b1;
            end else begin
                hCnt <= hCnt + 1'b1;
            end
        end
    end

    // Stored-line base: advances one stored line after every LINE_REP output lines.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lineBase <= '0;
            repCnt   <= '0;
        end else if (state == SCAN && hEnd) begin
            if (vEnd) begin
                lineBase <= '0;
                repCnt   <= '0;
            end else if (vCnt < VW'(V_ACTIVE)) begin
                if (repCnt == RW'(LINE_REP - 1)) begin
                    repCnt   <= '0;
                    lineBase <= lineBase + ADDR_W'(H_ACTIVE);
                end else begin
                    repCnt <= repCnt + 1'b1;
                end
            end
        end
    end

    // Read address for visible positions; holds its last value in blanking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          bus.ReadAdd <= '0;
        else if (pixActive) bus.ReadAdd <= lineBase + ADDR_W'(hCnt);
    end

    // Timing flags for the current raster position (all inactive while idle).
    always_comb begin
        ctrlNow = '0;
        if (state == SCAN) begin
            ctrlNow[C_HS] = (hCnt >= HW'(H_ACTIVE + H_FP)) && (hCnt < HW'(H_ACTIVE + H_FP + H_SYNC));
            ctrlNow[C_VS] = (vCnt >= VW'(V_ACTIVE + V_FP)) && (vCnt < VW'(V_ACTIVE + V_FP + V_SYNC));
            ctrlNow[C_DE] = pixActive;
            ctrlNow[C_FS] = (hCnt == '0) && (vCnt == '0);
        end
    end

    // Delay line keeping the timing flags in step with the buffer data.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [3:0] ctrl;
            if (gi == 0) begin : g_head
                // First stage captures the live raster flags.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) ctrl <= '0;
                    else       ctrl <= ctrlNow;
                end
            end else begin : g_tail
                // Later stages just shift.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) ctrl <= '0;
                    else       ctrl <= g_stage[gi-1].ctrl;
                end
            end
        end
    endgenerate

    // Output register: blank pixels outside the visible area, apply sync polarity.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.Pixel      <= '0;
            bus.DE         <= 1'b0;
            bus.FrameStart <= 1'b0;
            bus.HSync      <= SYNC_IDLE;
            bus.VSync      <= SYNC_IDLE;
        end else begin
            bus.Pixel      <= g_stage[STAGES-1].ctrl[C_DE] ? bus.ReadData : '0;
            bus.DE         <= g_stage[STAGES-1].ctrl[C_DE];
            bus.FrameStart <= g_stage[STAGES-1].ctrl[C_FS];
            bus.HSync      <= g_stage[STAGES-1].ctrl[C_HS] ^ SYNC_IDLE;
            bus.VSync      <= g_stage[STAGES-1].ctrl[C_VS] ^ SYNC_IDLE;
        end
    end

endmodule

// File: tb/tb_frame_scan_reader.sv
// Bench for frame_scan_reader: one instance at full 640x480 timing for the
// idle and first-lines checks, one shrunk instance (active-high syncs) for
// whole-frame, disable/restart and mid-frame reset behaviour.
module tb_frame_scan_reader;

    logic clk = 1'b0;
    logic rstnA = 1'b0;
    logic rstnB = 1'b0;

    always #5 clk = ~clk;

    frame_scan_reader_if #(.ADDR_W(19), .DATA_W(12)) busA ();
    frame_scan_reader_if #(.ADDR_W(19), .DATA_W(12)) busB ();

    frame_scan_reader #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .LINE_REP(2), .SYNC_POL(0), .ADDR_W(19), .DATA_W(12)
    ) dutA (.clk(clk), .rstn(rstnA), .bus(busA.master));

    frame_scan_reader #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .LINE_REP(2), .SYNC_POL(1), .ADDR_W(19), .DATA_W(12)
    ) dutB (.clk(clk), .rstn(rstnB), .bus(busB.master));

    // Frame buffer contents mem[a] = a[11:0], one-cycle registered read.
    always @(posedge clk) begin
        busA.ReadData <= busA.ReadAdd[11:0];
        busB.ReadData <= busB.ReadAdd[11:0];
    end

    int total = 0;
    int bad   = 0;

    // Mismatch record filled by scan(): DE, HSync, VSync, FrameStart, Pixel, ReadAdd.
    int          mmCnt  [6];
    int          mmK    [6];
    int          mmWant [6];
    logic [18:0] mmGot  [6];
    string       sigName[6] = '{"DE", "HSync", "VSync", "FrameStart", "Pixel", "ReadAdd"};

    // Walks n clocks (k = kFirst..kFirst+n-1 counted from the clock that
    // starts the scan) and tallies differences from an ideal raster whose
    // first output appears at k=4. 'frames' whole frames are shown, then idle.
    task automatic scan(input int sel, input string tag, input int kFirst, input int n,
                        input int frames, input int initAdd);
        int hA, hFp, hS, hT, vA, vFp, vS, vT, rep, pol, fLen, maxAddr;
        int k, p, q, pp, h, v;
        int xv[6];
        logic [18:0] ov[6];
        if (sel == 0) begin
            hA = 640; hFp = 16; hS = 96; hT = 800; vA = 480; vFp = 10; vS = 2; vT = 525; rep = 2; pol = 0;
        end else begin
            hA = 16; hFp = 2; hS = 3; hT = 25; vA = 8; vFp = 1; vS = 2; vT = 13; rep = 2; pol = 1;
        end
        fLen    = hT * vT;
        maxAddr = (vA / rep) * hA - 1;
        for (int j = 0; j < 6; j++) begin
            mmCnt[j] = 0; mmK[j] = 0; mmWant[j] = 0; mmGot[j] = '0;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            k = kFirst + i;
            p = k - 4;
            q = k - 2;
            for (int j = 0; j < 6; j++) xv[j] = 0;
            if (p >= 0 && p < frames * fLen) begin
                pp = p % fLen; h = pp % hT; v = pp / hT;
                xv[0] = (h < hA && v < vA) ? 1 : 0;
                xv[1] = (h >= hA + hFp && h < hA + hFp + hS) ? 1 : 0;
                xv[2] = (v >= vA + vFp && v < vA + vFp + vS) ? 1 : 0;
                xv[3] = (pp == 0) ? 1 : 0;
                xv[4] = (xv[0] == 1) ? (((v / rep) * hA + h) % 4096) : 0;
            end
            if (pol == 0) begin
                xv[1] = 1 - xv[1];
                xv[2] = 1 - xv[2];
            end
            if (q < 0) xv[5] = initAdd;
            else if (q >= frames * fLen) xv[5] = (frames > 0) ? maxAddr : initAdd;
            else begin
                pp = q % fLen; h = pp % hT; v = pp / hT;
                if (v >= vA)     xv[5] = maxAddr;
                else if (h < hA) xv[5] = (v / rep) * hA + h;
                else             xv[5] = (v / rep) * hA + hA - 1;
            end
            if (sel == 0) begin
                ov[0] = 19'(busA.DE); ov[1] = 19'(busA.HSync); ov[2] = 19'(busA.VSync);
                ov[3] = 19'(busA.FrameStart); ov[4] = 19'(busA.Pixel); ov[5] = busA.ReadAdd;
            end else begin
                ov[0] = 19'(busB.DE); ov[1] = 19'(busB.HSync); ov[2] = 19'(busB.VSync);
                ov[3] = 19'(busB.FrameStart); ov[4] = 19'(busB.Pixel); ov[5] = busB.ReadAdd;
            end
            for (int j = 0; j < 6; j++) begin
                if (ov[j] !== 19'(xv[j])) begin
                    if (mmCnt[j] == 0) begin
                        mmK[j] = k; mmGot[j] = ov[j]; mmWant[j] = xv[j];
                    end
                    mmCnt[j]++;
                end
            end
        end
        $display("scan %s: k=%0d..%0d observed", tag, kFirst, kFirst + n - 1);
    endtask

    // en=0 out of reset: everything stays at reset values.
    task automatic test_reset();
        busA.en = 1'b0;
        rstnA = 1'b0;
        @(negedge clk);
        #1;
        total += 6;
        if (busA.DE !== 1'b0) begin bad++; $display("FAIL reset.DE got %0b want 0", busA.DE); end
        if (busA.Pixel !== 12'h000) begin bad++; $display("FAIL reset.Pixel got %0h want 0", busA.Pixel); end
        if (busA.HSync !== 1'b1) begin bad++; $display("FAIL reset.HSync got %0b want 1", busA.HSync); end
        if (busA.VSync !== 1'b1) begin bad++; $display("FAIL reset.VSync got %0b want 1", busA.VSync); end
        if (busA.FrameStart !== 1'b0) begin bad++; $display("FAIL reset.FrameStart got %0b want 0", busA.FrameStart); end
        if (busA.ReadAdd !== 19'd0) begin bad++; $display("FAIL reset.ReadAdd got %0d want 0", busA.ReadAdd); end
        @(negedge clk);
        rstnA = 1'b1;
        scan(0, "idle", 1, 2000, 0, 0);
        for (int j = 0; j < 6; j++) begin
            total++;
            if (mmCnt[j] !== 0) begin
                bad++;
                $display("FAIL idle.%s %0d bad cycles, first k=%0d got %0d want %0d",
                         sigName[j], mmCnt[j], mmK[j], mmGot[j], mmWant[j]);
            end
        end
    endtask

    // en=1 from reset: first lines at full timing, including line doubling.
    task automatic test_stream();
        @(negedge clk);
        rstnA = 1'b0;
        busA.en = 1'b1;
        repeat (2) @(negedge clk);
        rstnA = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) begin
                total++;
                if (busA.DE !== 1'b0) begin bad++; $display("FAIL stream.DE_k3 got %0b want 0", busA.DE); end
            end
            if (k == 4) begin
                total += 3;
                if (busA.FrameStart !== 1'b1) begin bad++; $display("FAIL stream.FS_k4 got %0b want 1", busA.FrameStart); end
                if (busA.DE !== 1'b1) begin bad++; $display("FAIL stream.DE_k4 got %0b want 1", busA.DE); end
                if (busA.Pixel !== 12'h000) begin bad++; $display("FAIL stream.Pixel_k4 got %0h want 0", busA.Pixel); end
            end
            if (k == 5) begin
                total += 2;
                if (busA.FrameStart !== 1'b0) begin bad++; $display("FAIL stream.FS_k5 got %0b want 0", busA.FrameStart); end
                if (busA.Pixel !== 12'h001) begin bad++; $display("FAIL stream.Pixel_k5 got %0h want 1", busA.Pixel); end
            end
        end
        scan(0, "stream", 6, 2400, 1000, 0);
        for (int j = 0; j < 6; j++) begin
            total++;
            if (mmCnt[j] !== 0) begin
                bad++;
                $display("FAIL stream.%s %0d bad cycles, first k=%0d got %0d want %0d",
                         sigName[j], mmCnt[j], mmK[j], mmGot[j], mmWant[j]);
            end
        end
        rstnA = 1'b0;
    endtask

    // Small raster: two full frames back to back, well into the third.
    task automatic test_full_frame();
        busB.en = 1'b1;
        rstnB = 1'b0;
        repeat (2) @(negedge clk);
        rstnB = 1'b1;
        scan(1, "frames", 1, 750, 3, 0);
        for (int j = 0; j < 6; j++) begin
            total++;
            if (mmCnt[j] !== 0) begin
                bad++;
                $display("FAIL frames.%s %0d bad cycles, first k=%0d got %0d want %0d",
                         sigName[j], mmCnt[j], mmK[j], mmGot[j], mmWant[j]);
            end
        end
    endtask

    // en dropped mid third frame: frame completes, then idle; re-enable restarts.
    task automatic test_disable();
        busB.en = 1'b0;
        scan(1, "drain", 751, 285, 3, 0);
        for (int j = 0; j < 6; j++) begin
            total++;
            if (mmCnt[j] !== 0) begin
                bad++;
                $display("FAIL drain.%s %0d bad cycles, first k=%0d got %0d want %0d",
                         sigName[j], mmCnt[j], mmK[j], mmGot[j], mmWant[j]);
            end
        end
        busB.en = 1'b1;
        scan(1, "restart", 1, 135, 100, 63);
        for (int j = 0; j < 6; j++) begin
            total++;
            if (mmCnt[j] !== 0) begin
                bad++;
                $display("FAIL restart.%s %0d bad cycles, first k=%0d got %0d want %0d",
                         sigName[j], mmCnt[j], mmK[j], mmGot[j], mmWant[j]);
            end
        end
    endtask

    // Reset asserted mid-line 5 of a frame: immediate reset values, clean restart.
    task automatic test_reset_midframe();
        rstnB = 1'b0;
        #1;
        total += 6;
        if (busB.DE !== 1'b0) begin bad++; $display("FAIL midreset.DE got %0b want 0", busB.DE); end
        if (busB.Pixel !== 12'h000) begin bad++; $display("FAIL midreset.Pixel got %0h want 0", busB.Pixel); end
        if (busB.HSync !== 1'b0) begin bad++; $display("FAIL midreset.HSync got %0b want 0", busB.HSync); end
        if (busB.VSync !== 1'b0) begin bad++; $display("FAIL midreset.VSync got %0b want 0", busB.VSync); end
        if (busB.FrameStart !== 1'b0) begin bad++; $display("FAIL midreset.FrameStart got %0b want 0", busB.FrameStart); end
        if (busB.ReadAdd !== 19'd0) begin bad++; $display("FAIL midreset.ReadAdd got %0d want 0", busB.ReadAdd); end
        repeat (2) @(negedge clk);
        rstnB = 1'b1;
        scan(1, "post_reset", 1, 355, 100, 0);
        for (int j = 0; j < 6; j++) begin
            total++;
            if (mmCnt[j] !== 0) begin
                bad++;
                $display("FAIL post_reset.%s %0d bad cycles, first k=%0d got %0d want %0d",
                         sigName[j], mmCnt[j], mmK[j], mmGot[j], mmWant[j]);
            end
        end
    endtask

    initial begin
        busA.en = 1'b0;
        busB.en = 1'b0;
        test_reset();
        test_stream();
        test_full_frame();
        test_disable();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
